// File: rtl/ex_mem_pipe_stage_pkg.sv
// Shared definitions for the EX->MEM pipeline stage: default widths,
// writeback select encodings, the payload bundle and the skid buffer states.
package ex_mem_pipe_stage_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int RES_SRC_W_DEF  = 2;

    // Writeback mux select encodings carried in ResultSrc.
    typedef enum logic [RES_SRC_W_DEF-1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // Payload bundle at default widths; field order matches the packed
    // vector built by the top level (control bits in the MSBs).
    typedef struct packed {
        logic                      reg_write;
        logic                      mem_write;
        logic [REG_ADDR_W_DEF-1:0] rd;
        logic [RES_SRC_W_DEF-1:0]  result_src;
        logic [XLEN_DEF-1:0]       alu_result;
        logic [XLEN_DEF-1:0]       write_data;
        logic [XLEN_DEF-1:0]       pc_plus4;
    } ex_mem_bundle_t;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // Packed payload width for a given set of field widths.
    function automatic int bundle_width(input int xlen, input int reg_addr_w,
                                        input int res_src_w);
        return 2 + reg_addr_w + res_src_w + 3 * xlen;
    endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic ready/valid pipeline register with synchronous flush.
// SKID=1: two entries (main + skid) so the upstream ready is a flop and
// downstream backpressure never reaches upstream combinationally.
// SKID=0: a single entry whose upstream ready is combinational.
module pipe_skid_buffer
    import ex_mem_pipe_stage_pkg::*;
#(
    parameter int W    = 8,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    if (SKID) begin : g_skid
        skid_state_e  state_q, state_d;
        logic [W-1:0] main_q, main_d;
        logic [W-1:0] skid_q, skid_d;
        logic         ready_q;
        logic         accept;
        logic         emit;

        assign accept = valid_i && ready_q;
        assign emit   = (state_q != SKID_EMPTY) && ready_i;

        // Occupancy transitions; the skid entry only fills when main is
        // stalled, and drains into main as soon as main is consumed.
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            unique case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        state_d = SKID_ONE;
                        main_d  = data_i;
                    end
                end
                SKID_ONE: begin
                    if (accept && emit) begin
                        main_d = data_i;
                    end else if (accept) begin
                        state_d = SKID_TWO;
                        skid_d  = data_i;
                    end else if (emit) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (emit) begin
                        state_d = SKID_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
            // Flush wins over any same-cycle transfer; held entries are dropped.
            if (flush_i) begin
                state_d = SKID_EMPTY;
                main_d  = main_q;
                skid_d  = '0;
            end
        end

        // State, payload and the registered upstream ready.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= SKID_EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
                ready_q <= 1'b1;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
                ready_q <= (state_d != SKID_TWO);
            end
        end

        assign ready_o = ready_q;
        assign valid_o = (state_q != SKID_EMPTY);
        assign data_o  = main_q;
    end else begin : g_reg
        logic         valid_q, valid_d;
        logic [W-1:0] main_q, main_d;
        logic         ready;
        logic         accept;

        assign ready  = !valid_q || ready_i;
        assign accept = valid_i && ready;

        // Single entry: load on accept, clear when drained without a refill.
        always_comb begin
            valid_d = valid_q;
            main_d  = main_q;
            if (accept) begin
                valid_d = 1'b1;
                main_d  = data_i;
            end else if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
            if (flush_i) begin
                valid_d = 1'b0;
                main_d  = main_q;
            end
        end

        // Entry valid flag and payload.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                main_q  <= '0;
            end else begin
                valid_q <= valid_d;
                main_q  <= main_d;
            end
        end

        assign ready_o = ready;
        assign valid_o = valid_q;
        assign data_o  = main_q;
    end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage with ready/valid handshake, flush and optional
// skid buffer. Packs the EX bundle, passes it through the buffer and
// unpacks it on the MEM side, gating the write enables with ValidM.
module ex_mem_pipe_stage
    import ex_mem_pipe_stage_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int RES_SRC_W  = RES_SRC_W_DEF,
    parameter bit SKID       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ValidE,
    output logic                  ReadyE,
    input  logic                  RegWriteE,
    input  logic                  MemWriteE,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [RES_SRC_W-1:0]  ResultSrcE,
    input  logic [XLEN-1:0]       ALUResultE,
    input  logic [XLEN-1:0]       WriteDataE,
    input  logic [XLEN-1:0]       PCPlus4E,
    input  logic                  FlushM,
    output logic                  ValidM,
    input  logic                  ReadyM,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic [REG_ADDR_W-1:0] RdM,
    output logic [RES_SRC_W-1:0]  ResultSrcM,
    output logic [XLEN-1:0]       ALUResultM,
    output logic [XLEN-1:0]       WriteDataM,
    output logic [XLEN-1:0]       PCPlus4M
);

    localparam int PAY_W = bundle_width(XLEN, REG_ADDR_W, RES_SRC_W);

    logic [PAY_W-1:0] bundle_e;
    logic [PAY_W-1:0] bundle_m;
    logic             reg_write_raw;
    logic             mem_write_raw;

    assign bundle_e = {RegWriteE, MemWriteE, RdE, ResultSrcE,
                       ALUResultE, WriteDataE, PCPlus4E};

    pipe_skid_buffer #(
        .W    (PAY_W),
        .SKID (SKID)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (FlushM),
        .valid_i (ValidE),
        .ready_o (ReadyE),
        .data_i  (bundle_e),
        .valid_o (ValidM),
        .ready_i (ReadyM),
        .data_o  (bundle_m)
    );

    assign {reg_write_raw, mem_write_raw, RdM, ResultSrcM,
            ALUResultM, WriteDataM, PCPlus4M} = bundle_m;

    // Bubbles must never write the register file or memory.
    assign RegWriteM = ValidM && reg_write_raw;
    assign MemWriteM = ValidM && mem_write_raw;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: one SKID=1 and one SKID=0 instance share the
// EX-side stimulus; each has its own FIFO reference model.
module tb_ex_mem_pipe_stage;

    localparam int PW = 105;

    logic        clk = 1'b0;
    logic        rst_n, ValidE, RegWriteE, MemWriteE, FlushM, ReadyM;
    logic [4:0]  RdE;
    logic [1:0]  ResultSrcE;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E;

    logic        ReadyE_s, ValidM_s, RegWriteM_s, MemWriteM_s;
    logic [4:0]  RdM_s;
    logic [1:0]  ResultSrcM_s;
    logic [31:0] ALUResultM_s, WriteDataM_s, PCPlus4M_s;

    logic        ReadyE_r, ValidM_r, RegWriteM_r, MemWriteM_r;
    logic [4:0]  RdM_r;
    logic [1:0]  ResultSrcM_r;
    logic [31:0] ALUResultM_r, WriteDataM_r, PCPlus4M_r;

    always #5 clk = ~clk;

    ex_mem_pipe_stage #(.SKID(1'b1)) u_skid (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .ReadyE(ReadyE_s),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .ALUResultE(ALUResultE),
        .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .FlushM(FlushM),
        .ValidM(ValidM_s), .ReadyM(ReadyM), .RegWriteM(RegWriteM_s),
        .MemWriteM(MemWriteM_s), .RdM(RdM_s), .ResultSrcM(ResultSrcM_s),
        .ALUResultM(ALUResultM_s), .WriteDataM(WriteDataM_s),
        .PCPlus4M(PCPlus4M_s)
    );

    ex_mem_pipe_stage #(.SKID(1'b0)) u_reg (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .ReadyE(ReadyE_r),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .ALUResultE(ALUResultE),
        .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .FlushM(FlushM),
        .ValidM(ValidM_r), .ReadyM(ReadyM), .RegWriteM(RegWriteM_r),
        .MemWriteM(MemWriteM_r), .RdM(RdM_r), .ResultSrcM(ResultSrcM_r),
        .ALUResultM(ALUResultM_r), .WriteDataM(WriteDataM_r),
        .PCPlus4M(PCPlus4M_r)
    );

    // Reference model: each instance is a FIFO (depth 2 for SKID=1, depth 1
    // for SKID=0) holding whole bundles in acceptance order.
    logic [PW-1:0] q [2][$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  started  = 1'b0;
    bit  rst_applied = 1'b0;

    task automatic chk(input string name, input int id,
                       input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d at %0t: got %h expected %h",
                     name, id, $time, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] in_vec();
        return {RegWriteE, MemWriteE, RdE, ResultSrcE,
                ALUResultE, WriteDataE, PCPlus4E};
    endfunction

    task automatic mon(input int id, input logic vm, input logic re,
                       input logic [PW-1:0] outv);
        int sz;
        sz = q[id].size();
        if (started) begin
            chk("ValidM", id, PW'(vm), PW'(sz > 0));
            if (rst_applied) chk("reset_outputs", id, outv, '0);
            if (vm && sz > 0) chk("payload", id, outv, q[id][0]);
            if (!vm) chk("bubble_we_gating", id, PW'(outv[PW-1 -: 2]), '0);
            if (id == 0) chk("ReadyE_skid", id, PW'(re), PW'(sz < 2));
            else         chk("ReadyE_comb", id, PW'(re), PW'(!vm || ReadyM));
        end
        // Advance the model to what the coming edge does.
        if (!rst_n || FlushM) begin
            q[id].delete();
        end else begin
            if (vm && ReadyM && sz > 0) void'(q[id].pop_front());
            if (ValidE && re) q[id].push_back(in_vec());
        end
    endtask

    // Monitor: samples both instances on the falling edge.
    always @(negedge clk) begin
        mon(0, ValidM_s, ReadyE_s, {RegWriteM_s, MemWriteM_s, RdM_s,
            ResultSrcM_s, ALUResultM_s, WriteDataM_s, PCPlus4M_s});
        mon(1, ValidM_r, ReadyE_r, {RegWriteM_r, MemWriteM_r, RdM_r,
            ResultSrcM_r, ALUResultM_r, WriteDataM_r, PCPlus4M_r});
        rst_applied = !rst_n;
        if (!rst_n) started = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload();
        RegWriteE  = 1'($urandom);
        MemWriteE  = 1'($urandom);
        RdE        = 5'($urandom);
        ResultSrcE = 2'($urandom_range(0, 2));
        ALUResultE = $urandom;
        WriteDataE = $urandom;
        PCPlus4E   = $urandom;
    endtask

    logic [1:0]  rm_pat [3];
    logic [31:0] pc_vals [3];

    initial begin
        bit acc;
        int idx;
        rst_n = 1'b0; ValidE = 1'b1; FlushM = 1'b0; ReadyM = 1'b1;
        rand_payload();
        step(); step();
        rst_n = 1'b1;

        // Back-to-back streaming.
        for (int i = 0; i < 4; i++) begin
            rand_payload();
            ValidE = 1'b1; ALUResultE = 32'h10 * (i + 1);
            step();
        end
        ValidE = 1'b0;
        repeat (3) step();

        // Backpressure: A and B fill the stage, C waits for ReadyE.
        ReadyM = 1'b0;
        rand_payload(); ValidE = 1'b1; ALUResultE = 32'hA; step();
        rand_payload(); ALUResultE = 32'hB; step();
        rand_payload(); ALUResultE = 32'hC;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            if (k == 3) ReadyM = 1'b1;
            acc = ReadyE_s;
            step();
        end
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL backpressure_accept_C: ReadyE never returned");
        end
        ValidE = 1'b0; ReadyM = 1'b1;
        repeat (4) step();

        // Flush while two entries are held.
        ReadyM = 1'b0;
        rand_payload(); ValidE = 1'b1; step();
        rand_payload(); step();
        rand_payload(); RegWriteE = 1'b1; FlushM = 1'b1; step();
        FlushM = 1'b0; ValidE = 1'b0; step();
        ReadyM = 1'b1;
        repeat (3) step();

        // Bubbles carrying write enables.
        ValidE = 1'b0; RegWriteE = 1'b1; MemWriteE = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ReadyM = 1'($urandom);
            step();
        end

        // ReadyM 1,0,1 with continuous valid input on the SKID=0 instance.
        rm_pat  = '{2'd1, 2'd0, 2'd1};
        pc_vals = '{32'h4, 32'h8, 32'hC};
        idx = 0;
        ValidE = 1'b1;
        for (int k = 0; k < 20 && idx < 3; k++) begin
            ReadyM = rm_pat[k % 3][0];
            PCPlus4E = pc_vals[idx];
            #1;
            acc = ReadyE_r;
            step();
            if (acc) idx++;
        end
        n_checks++;
        if (idx != 3) begin
            n_fail++;
            $display("FAIL skid0_stream: accepted %0d of 3", idx);
        end
        ValidE = 1'b0; ReadyM = 1'b1;
        repeat (3) step();

        // Random traffic with occasional flush and reset.
        for (int k = 0; k < 600; k++) begin
            rand_payload();
            ValidE = ($urandom_range(0, 9) < 7);
            ReadyM = ($urandom_range(0, 9) < 6);
            FlushM = ($urandom_range(0, 31) == 0);
            rst_n  = ($urandom_range(0, 149) != 0);
            step();
        end
        rst_n = 1'b1; FlushM = 1'b0; ValidE = 1'b0; ReadyM = 1'b1;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
